mod16_count_monitor: RTL and testbench

- Downstream consumer of the mod-16 counter output. Samples the 4-bit count each enabled cycle and checks that it advances by exactly +1 mod 16.
- Produces wrap and compare-match pulses, and locks onto a valid sequence.
- Flags and counts step errors.
- Feeds the status/debug logic of the counter subsystem.

---
 rtl/mod16_count_monitor_pkg.sv | 13 +
 rtl/mod16_count_monitor_sat_counter.sv | 27 ++
 rtl/mod16_count_monitor.sv | 124 ++++++++++++
 tb/tb_mod16_count_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mod16_count_monitor_pkg.sv
// rtl/mod16_count_monitor_pkg.sv - shared types and defaults for the count monitor
package mod16_count_monitor_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_LOCK_STEPS = 3;

endpackage

// File: rtl/mod16_count_monitor_sat_counter.sv
// rtl/mod16_count_monitor_sat_counter.sv - saturating event counter with clear priority
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // clear beats a simultaneous increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mod16_count_monitor.sv
// rtl/mod16_count_monitor.sv - checks an upstream count advances by +1 mod 2**WIDTH,
// locks onto a valid sequence and reports wrap, match and step-error events
module mod16_count_monitor
  import mod16_count_monitor_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_STEPS = DEFAULT_LOCK_STEPS,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [WIDTH-1:0]      count_in,
  input  logic [WIDTH-1:0]      match_value,
  input  logic                  clear,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic                  match_pulse,
  output logic                  step_error,
  output logic                  error_sticky,
  output logic [ERR_CNT_W-1:0]  error_count,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  localparam int GOOD_W = (LOCK_STEPS < 2) ? 1 : $clog2(LOCK_STEPS + 1);

  state_t             state_q;
  logic [WIDTH-1:0]   prev_q;
  logic [GOOD_W-1:0]  good_q;
  logic               locked_q;
  logic               wrap_q;
  logic               match_q;
  logic               step_err_q;
  logic               sticky_q;

  logic [WIDTH-1:0]   prev_inc;
  logic               good_step;
  logic               err_ev;
  logic               wrap_ev;

  assign prev_inc  = prev_q + WIDTH'(1);
  assign good_step = en && (count_in == prev_inc);
  assign err_ev    = en && (state_q == LOCKED) && !good_step;
  assign wrap_ev   = en && (state_q == LOCKED) && good_step && (count_in == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ACQUIRE;
      prev_q     <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      match_q    <= 1'b0;
      step_err_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      wrap_q     <= wrap_ev;
      step_err_q <= err_ev;
      match_q    <= en && (count_in == match_value);
      if (clear) begin
        sticky_q <= 1'b0;
      end else if (err_ev) begin
        sticky_q <= 1'b1;
      end
      if (en) begin
        prev_q <= count_in;
        unique case (state_q)
          ACQUIRE: begin
            good_q  <= '0;
            state_q <= VERIFY;
          end
          VERIFY: begin
            if (good_step && (good_q == GOOD_W'(LOCK_STEPS - 1))) begin
              state_q  <= LOCKED;
              good_q   <= '0;
              locked_q <= 1'b1;
            end else if (good_step) begin
              good_q <= good_q + GOOD_W'(1);
            end else begin
              good_q <= '0;
            end
          end
          LOCKED: begin
            // a bad sample becomes the new reference for re-verification
            if (!good_step) begin
              state_q  <= VERIFY;
              good_q   <= '0;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ACQUIRE;
            good_q   <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk_i   (clk),
    .rst_n_i (reset),
    .inc_i   (err_ev),
    .clr_i   (clear),
    .count_o (error_count)
  );

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk_i   (clk),
    .rst_n_i (reset),
    .inc_i   (wrap_ev),
    .clr_i   (clear),
    .count_o (wrap_count)
  );

  assign locked       = locked_q;
  assign wrap_pulse   = wrap_q;
  assign match_pulse  = match_q;
  assign step_error   = step_err_q;
  assign error_sticky = sticky_q;

endmodule

// File: tb/tb_mod16_count_monitor.sv
// tb/tb_mod16_count_monitor.sv - self-checking bench for mod16_count_monitor
module tb_mod16_count_monitor;

  localparam int WIDTH      = 4;
  localparam int LOCK_STEPS = 3;
  localparam int ERR_CNT_W  = 2;
  localparam int WRAP_CNT_W = 8;
  localparam int MOD        = 1 << WIDTH;
  localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;
  localparam int WRAP_MAX   = (1 << WRAP_CNT_W) - 1;

  logic                  clk;
  logic                  reset;
  logic                  en;
  logic [WIDTH-1:0]      count_in;
  logic [WIDTH-1:0]      match_value;
  logic                  clear;
  logic                  locked;
  logic                  wrap_pulse;
  logic                  match_pulse;
  logic                  step_error;
  logic                  error_sticky;
  logic [ERR_CNT_W-1:0]  error_count;
  logic [WRAP_CNT_W-1:0] wrap_count;

  int checks = 0;
  int errors = 0;

  mod16_count_monitor #(
    .WIDTH(WIDTH), .LOCK_STEPS(LOCK_STEPS),
    .ERR_CNT_W(ERR_CNT_W), .WRAP_CNT_W(WRAP_CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .count_in(count_in),
    .match_value(match_value), .clear(clear), .locked(locked),
    .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
    .step_error(step_error), .error_sticky(error_sticky),
    .error_count(error_count), .wrap_count(wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: locked means a reference exists and the current run of
  // consecutive +1 steps since the last bad step is at least LOCK_STEPS.
  int m_have_ref, m_ref, m_run, m_good, m_was_locked;
  int m_locked, m_wrap, m_match, m_err, m_sticky, m_errcnt, m_wrapcnt;

  always @(negedge reset) begin
    m_have_ref = 0; m_ref = 0; m_run = 0;
    m_locked = 0; m_wrap = 0; m_match = 0; m_err = 0;
    m_sticky = 0; m_errcnt = 0; m_wrapcnt = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_wrap = 0; m_err = 0; m_match = 0;
      if (en) begin
        m_match      = (count_in == match_value) ? 1 : 0;
        m_good       = (m_have_ref != 0 && int'(count_in) == (m_ref + 1) % MOD) ? 1 : 0;
        m_was_locked = (m_have_ref != 0 && m_run >= LOCK_STEPS) ? 1 : 0;
        if (m_was_locked != 0 && m_good == 0) begin
          m_err = 1;
          m_sticky = 1;
          if (m_errcnt < ERR_MAX) m_errcnt = m_errcnt + 1;
        end
        if (m_was_locked != 0 && m_good != 0 && count_in == 0) begin
          m_wrap = 1;
          if (m_wrapcnt < WRAP_MAX) m_wrapcnt = m_wrapcnt + 1;
        end
        m_run = (m_good != 0) ? m_run + 1 : 0;
        m_have_ref = 1;
        m_ref = int'(count_in);
      end
      if (clear) begin
        m_errcnt = 0; m_wrapcnt = 0; m_sticky = 0;
      end
      m_locked = (m_have_ref != 0 && m_run >= LOCK_STEPS) ? 1 : 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("locked",       int'(locked),       m_locked);
      chk("wrap_pulse",   int'(wrap_pulse),   m_wrap);
      chk("match_pulse",  int'(match_pulse),  m_match);
      chk("step_error",   int'(step_error),   m_err);
      chk("error_sticky", int'(error_sticky), m_sticky);
      chk("error_count",  int'(error_count),  m_errcnt);
      chk("wrap_count",   int'(wrap_count),   m_wrapcnt);
    end
  end

  task automatic step(input logic e, input int c);
    en = e;
    count_in = WIDTH'(c % MOD);
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; count_in = '0; match_value = 4'd15; clear = 1'b0;
    #1 reset = 1'b0;
    #2 cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_locked", int'(locked), 0);
    chk("rst_error_count", int'(error_count), 0);
    chk("rst_wrap_count", int'(wrap_count), 0);
    reset = 1'b1;

    // acquire and lock on 0,1,2,3
    step(1, 0); step(1, 1); step(1, 2);
    chk("lock_not_yet", int'(locked), 0);
    step(1, 3);
    chk("lock_after_3", int'(locked), 1);
    chk("lock_no_err", int'(step_error), 0);

    // wrap through 15 -> 0
    for (int c = 4; c <= 15; c++) step(1, c);
    step(1, 0);
    chk("wrap_pulse_at_0", int'(wrap_pulse), 1);
    chk("wrap_count_1", int'(wrap_count), 1);
    step(1, 1);
    chk("wrap_pulse_gone", int'(wrap_pulse), 0);

    // skip 6 -> 8 while locked
    for (int c = 2; c <= 6; c++) step(1, c);
    step(1, 8);
    chk("skip_step_error", int'(step_error), 1);
    chk("skip_error_count", int'(error_count), 1);
    chk("skip_sticky", int'(error_sticky), 1);
    chk("skip_unlocked", int'(locked), 0);
    step(1, 9); step(1, 10); step(1, 11);
    chk("relock", int'(locked), 1);
    chk("relock_sticky", int'(error_sticky), 1);

    // match pulses with an en=0 gap and a held value
    match_value = 4'd7;
    for (int c = 12; c <= 22; c++) step(1, c);
    step(1, 7);
    chk("match_first", int'(match_pulse), 1);
    step(0, 7);
    chk("match_en0", int'(match_pulse), 0);
    chk("err_en0", int'(step_error), 0);
    step(1, 7);
    chk("match_second", int'(match_pulse), 1);
    chk("held_step_error", int'(step_error), 1);
    chk("held_error_count", int'(error_count), 2);

    // saturation of the 2-bit error counter
    step(1, 8); step(1, 9); step(1, 10);
    step(1, 12);
    step(1, 13); step(1, 14); step(1, 15);
    step(1, 0);
    chk("err_saturated", int'(error_count), 3);
    step(1, 1); step(1, 2); step(1, 3);
    clear = 1'b1;
    step(1, 9);
    clear = 1'b0;
    chk("clr_step_error", int'(step_error), 1);
    chk("clr_error_count", int'(error_count), 0);
    chk("clr_sticky", int'(error_sticky), 0);

    // asynchronous reset while locked at 10
    for (int c = 10; c <= 26; c++) step(1, c);
    chk("locked_at_10", int'(locked), 1);
    #2 reset = 1'b0;
    en = 1'b0;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_wrap_count", int'(wrap_count), 0);
    #9 reset = 1'b1;
    step(1, 11);
    chk("post_rst_no_lock", int'(locked), 0);
    step(1, 12); step(1, 13);
    chk("post_rst_verify", int'(locked), 0);
    step(1, 14);
    chk("post_rst_lock", int'(locked), 1);
    step(0, 0);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
